// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder; optional subtract via SERIAL_ADDER_SUB_EN
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             c_ff_q, c_ff_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic             ha1_s, ha1_c, ha2_s, ha2_c, fa_c;
  logic             load_sub;
  logic [WIDTH-1:0] load_b;

  // Full-adder slice built from two half adders on the current LSBs and the carry FF
  assign ha1_s = a_sh_q[0] ^ b_sh_q[0];
  assign ha1_c = a_sh_q[0] & b_sh_q[0];
  assign ha2_s = ha1_s ^ c_ff_q;
  assign ha2_c = ha1_s & c_ff_q;
  assign fa_c  = ha1_c | ha2_c;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is A + ~B + 1: invert B at load and seed the carry with 1
  assign load_sub = SUB;
`else
  assign load_sub = 1'b0;
`endif
  assign load_b = load_sub ? ~B : B;

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      s_sh_q    <= '0;
      c_ff_q    <= 1'b0;
      bit_cnt_q <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      s_sh_q    <= s_sh_d;
      c_ff_q    <= c_ff_d;
      bit_cnt_q <= bit_cnt_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
    end
  end

  // Next-state logic: load on START in IDLE, one bit per cycle in RUN, single DONE cycle
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    s_sh_d    = s_sh_q;
    c_ff_d    = c_ff_q;
    bit_cnt_d = bit_cnt_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          a_sh_d    = A;
          b_sh_d    = load_b;
          c_ff_d    = load_sub;
          s_sh_d    = '0;
          bit_cnt_d = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        s_sh_d = {ha2_s, s_sh_q[WIDTH-1:1]};
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        c_ff_d = fa_c;
        if (bit_cnt_q == LAST_BIT) begin
          // Counter parks at its terminal value; it is reloaded on the next START
          sum_d   = {ha2_s, s_sh_q[WIDTH-1:1]};
          carry_d = fa_c;
          state_d = ST_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign BUSY  = (state_q != ST_IDLE);
  assign DONE  = (state_q == ST_DONE);
  assign SUM   = sum_q;
  assign CARRY = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder against a cycle-count reference model
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST_r = 1'b1;
  logic             START_r = 1'b0;
  logic [WIDTH-1:0] A_r = '0;
  logic [WIDTH-1:0] B_r = '0;
  logic             sub_r = 1'b0;
  logic             BUSY, DONE, CARRY;
  logic [WIDTH-1:0] SUM;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .RST   (RST_r),
    .START (START_r),
    .A     (A_r),
    .B     (B_r),
`ifdef SERIAL_ADDER_SUB_EN
    .SUB   (sub_r),
`endif
    .BUSY  (BUSY),
    .DONE  (DONE),
    .SUM   (SUM),
    .CARRY (CARRY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Reference model: an accepted request keeps the block busy for WIDTH+1 cycles, the last one flagged DONE
  int               m_cnt = 0;
  logic [WIDTH-1:0] m_sum = '0;
  logic             m_carry = 1'b0;
  logic [WIDTH-1:0] p_sum;
  logic             p_carry;

  function automatic bit sub_eff(input logic s);
`ifdef SERIAL_ADDER_SUB_EN
    return s;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge CLK) begin
    logic [WIDTH:0] tot;
    if (RST_r) begin
      m_cnt   = 0;
      m_sum   = '0;
      m_carry = 1'b0;
    end else if (m_cnt == 0) begin
      if (START_r) begin
        m_cnt = WIDTH + 1;
        if (sub_eff(sub_r)) begin
          p_sum   = A_r - B_r;
          p_carry = (A_r >= B_r);
        end else begin
          tot     = {1'b0, A_r} + {1'b0, B_r};
          p_sum   = tot[WIDTH-1:0];
          p_carry = tot[WIDTH];
        end
      end
    end else begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 1) begin
        m_sum   = p_sum;
        m_carry = p_carry;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      check("busy",  BUSY,  (m_cnt != 0));
      check("done",  DONE,  (m_cnt == 1));
      check("sum",   SUM,   m_sum);
      check("carry", CARRY, m_carry);
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                        input logic [WIDTH-1:0] a_after, input logic [WIDTH-1:0] b_after,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_carry, input string name);
    int busy_n;
    int done_at;
    A_r = a; B_r = b; sub_r = sub; START_r = 1'b1;
    tick();
    START_r = 1'b0; A_r = a_after; B_r = b_after; sub_r = ~sub;
    busy_n = 0;
    done_at = -1;
    for (int n = 0; n < 40; n++) begin
      if (!BUSY) break;
      busy_n++;
      if (DONE) begin
        done_at = n;
        check({name, "_sum"},   SUM,   exp_sum);
        check({name, "_carry"}, CARRY, exp_carry);
      end
      tick();
    end
    check({name, "_done_edge"},   done_at, WIDTH);
    check({name, "_busy_cycles"}, busy_n,  WIDTH + 1);
  endtask

  initial begin
    int done_n;
    tick();
    tick();
    chk_en = 1'b1;
    check("reset_busy",  BUSY,  0);
    check("reset_done",  DONE,  0);
    check("reset_sum",   SUM,   0);
    check("reset_carry", CARRY, 0);
    RST_r = 1'b0;
    tick();

    run_op(8'h00, 8'h00, 1'b0, 8'h3C, 8'hC3, 8'h00, 1'b0, "zero");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, "ff_p_01");
    run_op(8'hA5, 8'h5A, 1'b0, 8'h11, 8'h22, 8'hFF, 1'b0, "a5_p_5a");
    run_op(8'h01, 8'h02, 1'b0, 8'hFF, 8'hFF, 8'h03, 1'b0, "ab_change");

    // START held high: one acceptance every WIDTH+2 cycles
    A_r = 8'h10; B_r = 8'h20; sub_r = 1'b0; START_r = 1'b1;
    done_n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (DONE) done_n++;
    end
    START_r = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (DONE) done_n++;
    end
    check("held_done_count", done_n, 3);
    check("held_sum", SUM, 8'h30);

    // Reset asserted on the 4th RUN cycle aborts the operation
    A_r = 8'h7F; B_r = 8'h7F; START_r = 1'b1;
    tick();
    START_r = 1'b0;
    tick(); tick(); tick();
    RST_r = 1'b1;
    tick();
    RST_r = 1'b0;
    check("abort_busy",  BUSY,  0);
    check("abort_done",  DONE,  0);
    check("abort_sum",   SUM,   0);
    check("abort_carry", CARRY, 0);
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (DONE) done_n++;
    end
    check("abort_no_done", done_n, 0);
    run_op(8'h03, 8'h04, 1'b0, 8'h99, 8'h66, 8'h07, 1'b0, "after_abort");

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 8'h00, 8'h00, 8'hFE, 1'b0, "sub_borrow");
    run_op(8'h07, 8'h05, 1'b1, 8'h00, 8'h00, 8'h02, 1'b1, "sub_noborrow");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, "sub0_ff_p_01");
    run_op(8'hA5, 8'h5A, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, "sub0_a5_p_5a");
`endif

    // Randomized traffic, including START during busy and occasional reset
    for (int i = 0; i < 800; i++) begin
      START_r = 1'($urandom_range(0, 1));
      A_r     = WIDTH'($urandom);
      B_r     = WIDTH'($urandom);
      sub_r   = 1'($urandom_range(0, 1));
      RST_r   = ($urandom_range(0, 99) == 0);
      tick();
    end
    RST_r = 1'b0;
    START_r = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
